// File: rtl/crc_encode_scheduler_if.sv
// ---------------------------------------------------------------------------
// crc_encode_scheduler_if
//   Bundles the requester, engine and result ports of crc_encode_scheduler.
//   master : scheduler side (drives req_ready, eng_*, out_*, busy)
//   slave  : environment side (byte sources, CRC engine, result consumer)
//   Signals:
//     req_valid/req_data/req_ready : NUM_REQ byte requesters, byte i at [8i+7:8i]
//     eng_start/eng_data           : launch pulse and payload to the CRC engine
//     eng_done/eng_codeword        : engine result {data, crc4}
//     out_valid/out_ready          : result handshake
//     out_codeword/out_id/out_timeout : result, owner id, abort flag
//     busy                         : scheduler not idle
// ---------------------------------------------------------------------------
interface crc_encode_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 eng_start;
    logic [7:0]           eng_data;
    logic                 eng_done;
    logic [11:0]          eng_codeword;
    logic                 out_valid;
    logic [11:0]          out_codeword;
    logic [ID_W-1:0]      out_id;
    logic                 out_timeout;
    logic                 out_ready;
    logic                 busy;

    modport master (
        input  req_valid, req_data, eng_done, eng_codeword, out_ready,
        output req_ready, eng_start, eng_data, out_valid, out_codeword,
               out_id, out_timeout, busy
    );

    modport slave (
        output req_valid, req_data, eng_done, eng_codeword, out_ready,
        input  req_ready, eng_start, eng_data, out_valid, out_codeword,
               out_id, out_timeout, busy
    );
endinterface

// File: rtl/crc_encode_scheduler.sv
// ---------------------------------------------------------------------------
// crc_encode_scheduler
//   Shares one CRC-4 encode engine among NUM_REQ byte requesters. Picks a
//   requester round-robin, launches the engine with a one-cycle start pulse,
//   waits for done (aborting after TIMEOUT cycles in WAIT) and returns the
//   codeword tagged with the requester id over a valid/ready port.
//   Ports:
//     clk : clock
//     rst : synchronous, active-high reset
//     bus : crc_encode_scheduler_if.master (requesters, engine, result, busy)
//   All outputs are registered except req_ready, which is decoded from the
//   state, the round-robin pointer and req_valid.
// ---------------------------------------------------------------------------
module crc_encode_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    crc_encode_scheduler_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DELIVER} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [ID_W-1:0]      r_last;
    logic [ID_W-1:0]      r_id;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_eng_start;
    logic [7:0]           r_eng_data;
    logic                 r_out_valid;
    logic [11:0]          r_out_cw;
    logic                 r_out_to;
    logic                 r_busy;

    logic [NUM_REQ-1:0]   w_grant;
    logic [ID_W-1:0]      w_win_id;
    logic                 w_found;
    logic [ID_W:0]        w_cand;
    logic [7:0]           w_sel;
    logic                 w_accept;
    logic                 w_tmo;

    assign w_tmo = (r_cnt == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_LAUNCH;
            S_LAUNCH:  w_next = S_WAIT;
            S_WAIT:    if (bus.eng_done || w_tmo) w_next = S_DELIVER;
            S_DELIVER: if (bus.out_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Grant decode: search last+1, last+2, ... wrapping at NUM_REQ, so the
    // most recent winner always drops to lowest priority.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        w_cand   = '0;
        w_sel    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_last} + (ID_W+1)'(k);
            if (w_cand >= (ID_W+1)'(NUM_REQ)) w_cand = w_cand - (ID_W+1)'(NUM_REQ);
            if (!w_found && bus.req_valid[w_cand[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_win_id = w_cand[ID_W-1:0];
            end
        end
        w_accept = (r_state == S_IDLE) && !rst && w_found;
        w_grant  = w_accept ? (NUM_REQ'(1) << w_win_id) : '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (w_grant[i]) w_sel = bus.req_data[i*8 +: 8];
    end

    // Registered outputs and datapath. eng_done only matters in WAIT, so a
    // late or stray done elsewhere cannot touch the result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last      <= ID_W'(NUM_REQ - 1);
            r_id        <= '0;
            r_cnt       <= '0;
            r_eng_start <= 1'b0;
            r_eng_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_cw    <= '0;
            r_out_to    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_eng_start <= w_accept;
            r_out_valid <= (w_next == S_DELIVER);
            r_busy      <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_eng_data <= w_sel;
                    r_id       <= w_win_id;
                    r_last     <= w_win_id;
                end
                S_LAUNCH: r_cnt <= '0;
                S_WAIT: begin
                    if (bus.eng_done) begin
                        r_out_cw <= bus.eng_codeword;
                        r_out_to <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_tmo) begin
                            r_out_cw <= '0;
                            r_out_to <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = w_grant;
    assign bus.eng_start    = r_eng_start;
    assign bus.eng_data     = r_eng_data;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_codeword = r_out_cw;
    assign bus.out_id       = r_id;
    assign bus.out_timeout  = r_out_to;
    assign bus.busy         = r_busy;

endmodule
